// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the execute-stage datapath: word width, divider
// FSM states and the M-extension funct3 codes used by the decoder.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } div_state_e;

   // The decoder derives is_signed and the quotient/remainder select from these
   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] i_r,
   input  logic            i_q_msb,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN-1:0] o_r,
   output logic            o_q_bit
);

   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_t;

   // The remainder stays below the divisor, so the shifted value needs one
   // extra bit and the subtract result always fits back into XLEN bits.
   assign w_shift = {i_r, i_q_msb};
   assign w_t     = w_shift + ~{1'b0, i_divisor} + {{XLEN{1'b0}}, 1'b1};
   assign o_q_bit = ~w_t[XLEN];
   assign o_r     = o_q_bit ? w_t[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU: one quotient bit
// per clock, with divide-by-zero and signed overflow resolved at capture.
module seq_divider
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e       r_state;
   div_state_e       w_state_next;
   logic [CNT_W-1:0] r_count;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_quo;
   logic [XLEN-1:0]  r_dvs;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_done;
   logic [XLEN-1:0]  r_quotient;
   logic [XLEN-1:0]  r_remainder;

   logic             w_div_zero;
   logic             w_overflow;
   logic             w_neg_a;
   logic             w_neg_b;
   logic [XLEN-1:0]  w_abs_a;
   logic [XLEN-1:0]  w_abs_b;
   logic [XLEN-1:0]  w_r_next;
   logic             w_q_bit;

   assign w_div_zero = (divisor == '0);
   assign w_overflow = is_signed && (dividend == INT_MIN) && (divisor == '1);
   assign w_neg_a    = is_signed && dividend[XLEN-1];
   assign w_neg_b    = is_signed && divisor[XLEN-1];
   assign w_abs_a    = w_neg_a ? (~dividend + 1'b1) : dividend;
   assign w_abs_b    = w_neg_b ? (~divisor + 1'b1) : divisor;

   div_step u_step (
      .i_r       (r_rem),
      .i_q_msb   (r_quo[XLEN-1]),
      .i_divisor (r_dvs),
      .o_r       (w_r_next),
      .o_q_bit   (w_q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start) w_state_next = (w_div_zero || w_overflow) ? FINISH : RUN;
         end
         RUN: begin
            if (r_count == CNT_W'(XLEN-1)) w_state_next = FINISH;
         end
         FINISH:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Special cases preload the final result and clear the negate flags so the
   // FINISH correction passes them through untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count     <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_count <= '0;
                  r_dvs   <= w_abs_b;
                  if (w_div_zero) begin
                     r_quo   <= '1;
                     r_rem   <= dividend;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                  end else if (w_overflow) begin
                     r_quo   <= INT_MIN;
                     r_rem   <= '0;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                  end else begin
                     r_quo   <= w_abs_a;
                     r_rem   <= '0;
                     r_neg_q <= w_neg_a ^ w_neg_b;
                     r_neg_r <= w_neg_a;
                  end
               end
            end
            RUN: begin
               r_rem   <= w_r_next;
               r_quo   <= {r_quo[XLEN-2:0], w_q_bit};
               r_count <= r_count + 1'b1;
            end
            FINISH: begin
               r_quotient  <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
               r_remainder <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
               r_done      <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (r_state != IDLE);
   assign done      = r_done;
   assign quotient  = r_quotient;
   assign remainder = r_remainder;

endmodule
